// File: rtl/rns_stream_alu_pkg.sv
// Shared types and constants for the streaming RNS element-wise ALU.
package rns_stream_alu_pkg;

  localparam int unsigned COEFF_W = 16;
  localparam int unsigned NCOEFF  = 8;
  localparam int unsigned NPRIMES = 3;
  localparam int unsigned TOTAL   = NCOEFF * NPRIMES;
  localparam int unsigned LAT     = 2;
  localparam int unsigned PIDX_W  = (NPRIMES > 1) ? $clog2(NPRIMES) : 1;
  localparam int unsigned CNT_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [PIDX_W-1:0]  pidx_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam coeff_t PRIMES [NPRIMES] = '{16'd65521, 16'd65519, 16'd65497};

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_NEG  = 2'd2,
    OP_PASS = 2'd3
  } rns_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Modulus lookup that stays in range for any index encoding.
  function automatic coeff_t prime_of(input pidx_t idx);
    coeff_t r;
    r = PRIMES[0];
    for (int unsigned i = 0; i < NPRIMES; i++) begin
      if (idx == pidx_t'(i)) r = PRIMES[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rns_stream_alu_mod_addsub.sv
// Two-stage modular add/sub/neg/pass datapath: stage 1 holds raw and
// corrected results plus the select flag, stage 2 drives the result stream.
module rns_mod_addsub
  import rns_stream_alu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  logic    in_last,
  input  rns_op_e op,
  input  coeff_t  a,
  input  coeff_t  b,
  input  coeff_t  q,
  output logic    stage1_valid,
  output logic    out_valid,
  output logic    out_last,
  output coeff_t  result
);

  localparam int unsigned WW = COEFF_W + 1;

  logic [WW-1:0] a_w, b_w, q_w, raw_w, corr_w;
  logic          flag;
  logic          s1_last, s1_flag;
  coeff_t        s1_raw, s1_corr;

  assign a_w = WW'(a);
  assign b_w = WW'(b);
  assign q_w = WW'(q);

  // flag selects the corrected value in stage 2.
  always_comb begin
    raw_w  = a_w;
    corr_w = a_w;
    flag   = 1'b0;
    case (op)
      OP_ADD: begin
        raw_w  = a_w + b_w;
        corr_w = a_w + b_w - q_w;
        flag   = (a_w + b_w) >= q_w;
      end
      OP_SUB: begin
        raw_w  = a_w - b_w;
        corr_w = a_w - b_w + q_w;
        flag   = a_w < b_w;
      end
      OP_NEG: begin
        corr_w = q_w - a_w;
        flag   = (a != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_valid <= 1'b0;
      s1_last      <= 1'b0;
      s1_flag      <= 1'b0;
      s1_raw       <= '0;
      s1_corr      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      result       <= '0;
    end else begin
      stage1_valid <= in_valid;
      s1_last      <= in_valid & in_last;
      s1_flag      <= flag;
      s1_raw       <= raw_w[COEFF_W-1:0];
      s1_corr      <= corr_w[COEFF_W-1:0];
      out_valid    <= stage1_valid;
      out_last     <= stage1_valid & s1_last;
      if (stage1_valid) result <= s1_flag ? s1_corr : s1_raw;
    end
  end

endmodule

// File: rtl/rns_stream_alu.sv
// Streaming RNS element-wise ALU: pairs source streams, tags each residue with
// its prime and feeds the modular datapath. Optional RNS_ALU_RANGE_CHECK_EN.
module rns_stream_alu
  import rns_stream_alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_operation,
  input  logic [1:0] opcode,
  input  logic       use_source1,
  input  logic       source0_valid,
  input  coeff_t     source0_coefficient,
  input  logic       source0_last,
  input  logic       source1_valid,
  input  coeff_t     source1_coefficient,
  input  logic       source1_last,
  output logic       destination_valid,
  output coeff_t     destination_coefficient,
  output logic       destination_last,
  output logic       busy,
  output logic       error
);

  state_e  state, state_next;
  rns_op_e op_q;
  logic    bin_q;
  pidx_t   prime_idx;
  cnt_t    elem_cnt;
  coeff_t  q_cur, operand_b;
  logic    pair_ok, pair_mismatch, accept, last_in, at_limit, range_err;
  logic    start_accept, final_elem, err_set, stage1_valid;

  assign q_cur         = prime_of(prime_idx);
  assign operand_b     = bin_q ? source1_coefficient : '0;
  assign pair_ok       = bin_q ? (source0_valid & source1_valid) : source0_valid;
  assign pair_mismatch = bin_q & (source0_valid ^ source1_valid);
  assign accept        = (state == ST_RUN) & pair_ok;
  assign last_in       = source0_last & (~bin_q | source1_last);
  assign at_limit      = (elem_cnt == cnt_t'(TOTAL - 1));

`ifdef RNS_ALU_RANGE_CHECK_EN
  assign range_err = accept & ((source0_coefficient >= q_cur) |
                               (bin_q & (source1_coefficient >= q_cur)));
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Early or missing last still closes the window; only the error differs.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    final_elem   = 1'b0;
    err_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_operation) begin
          start_accept = 1'b1;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        final_elem = accept & (last_in | at_limit);
        err_set    = pair_mismatch | (accept & (last_in != at_limit)) | range_err;
        if (final_elem) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!stage1_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_ADD;
      bin_q     <= 1'b0;
      prime_idx <= '0;
      elem_cnt  <= '0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (start_accept) begin
        op_q      <= rns_op_e'(opcode);
        bin_q     <= use_source1;
        prime_idx <= '0;
        elem_cnt  <= '0;
        error     <= 1'b0;
      end else begin
        if (accept) begin
          elem_cnt  <= elem_cnt + cnt_t'(1);
          prime_idx <= (prime_idx == pidx_t'(NPRIMES - 1)) ? '0 : prime_idx + pidx_t'(1);
        end
        if (err_set) error <= 1'b1;
      end
    end
  end

  rns_mod_addsub u_datapath (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (accept),
    .in_last      (final_elem),
    .op           (op_q),
    .a            (source0_coefficient),
    .b            (operand_b),
    .q            (q_cur),
    .stage1_valid (stage1_valid),
    .out_valid    (destination_valid),
    .out_last     (destination_last),
    .result       (destination_coefficient)
  );

endmodule

// File: tb/tb_rns_stream_alu.sv
// Self-checking bench for rns_stream_alu: directed streams with random
// operands against a modular-arithmetic scoreboard.
module tb_rns_stream_alu;
  import rns_stream_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start_operation, use_source1;
  logic [1:0] opcode;
  logic       source0_valid, source0_last, source1_valid, source1_last;
  coeff_t     source0_coefficient, source1_coefficient;
  logic       destination_valid, destination_last, busy, error;
  coeff_t     destination_coefficient;

  typedef struct {
    int val;
    bit last;
    bit chk;
  } exp_t;

  exp_t    sb[$];
  exp_t    mon_e;
  int      vectors = 0;
  int      miscompares = 0;
  int      n_last = 0;
  int      m_lasts = 0;
  bit      m_run, m_bin, m_err;
  rns_op_e m_op;
  int      m_cnt;

  always #5 clk = ~clk;

  rns_stream_alu dut (
    .clk                     (clk),
    .reset                   (reset),
    .start_operation         (start_operation),
    .opcode                  (opcode),
    .use_source1             (use_source1),
    .source0_valid           (source0_valid),
    .source0_coefficient     (source0_coefficient),
    .source0_last            (source0_last),
    .source1_valid           (source1_valid),
    .source1_coefficient     (source1_coefficient),
    .source1_last            (source1_last),
    .destination_valid       (destination_valid),
    .destination_coefficient (destination_coefficient),
    .destination_last        (destination_last),
    .busy                    (busy),
    .error                   (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_res(input rns_op_e op, input int a, input int b, input int q);
    case (op)
      OP_ADD:  return (a + b) % q;
      OP_SUB:  return ((a - b) % q + q) % q;
      OP_NEG:  return (q - a) % q;
      default: return a;
    endcase
  endfunction

  // Scoreboard consumer: every destination beat must match the next expected element.
  always @(negedge clk) begin
    if (destination_valid) begin
      if (destination_last) n_last++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) chk("result", 32'(destination_coefficient), 32'(mon_e.val));
        chk("dest_last", 32'(destination_last), 32'(mon_e.last));
      end
    end
  end

  task automatic start_op(input rns_op_e op, input bit bin);
    start_operation = 1'b1;
    opcode          = op;
    use_source1     = bin;
    tick();
    start_operation = 1'b0;
    m_run = 1; m_bin = bin; m_op = op; m_cnt = 0; m_err = 0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_clr_on_start", 32'(error), 32'd0);
  endtask

  task automatic send(input int a, input int b, input bit v0, input bit v1,
                      input bit l0, input bit l1);
    bit acc, lin, fin, rng;
    int q;
    source0_valid = v0; source0_coefficient = COEFF_W'(a); source0_last = l0;
    source1_valid = v1; source1_coefficient = COEFF_W'(b); source1_last = l1;
    acc = m_run && (m_bin ? (v0 && v1) : v0);
    if (m_run && m_bin && (v0 != v1)) m_err = 1;
    if (acc) begin
      q   = int'(PRIMES[m_cnt % NPRIMES]);
      lin = l0 && (!m_bin || l1);
      fin = lin || (m_cnt == TOTAL - 1);
      if (lin != (m_cnt == TOTAL - 1)) m_err = 1;
      rng = (a >= q) || (m_bin && b >= q);
`ifdef RNS_ALU_RANGE_CHECK_EN
      if (rng) m_err = 1;
`endif
      sb.push_back('{val: exp_res(m_op, a, b, q), last: fin, chk: !rng});
      m_cnt++;
      if (fin) begin
        m_run = 0;
        m_lasts++;
      end
    end
    tick();
    source0_valid = 1'b0; source1_valid = 1'b0;
    source0_last  = 1'b0; source1_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(tag, 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("error_state", 32'(error), 32'(m_err));
  endtask

  // kind: 0 ramp, 1 all q-1, 2 constant 3/5, 3 alternating 0/1, 4 random.
  task automatic stream(input rns_op_e op, input bit bin, input int kind);
    int a, b, q;
    bit fin;
    start_op(op, bin);
    for (int c = 0; c < NCOEFF; c++) begin
      for (int p = 0; p < NPRIMES; p++) begin
        q = int'(PRIMES[p]);
        case (kind)
          0:       begin a = c + p;           b = 4 * c + p + 10; end
          1:       begin a = q - 1;           b = q - 1;          end
          2:       begin a = 3;               b = 5;              end
          3:       begin a = (c + p) % 2;     b = 0;              end
          default: begin a = int'($urandom % 32'(q)); b = int'($urandom % 32'(q)); end
        endcase
        fin = (c == NCOEFF - 1) && (p == NPRIMES - 1);
        send(a, b, 1'b1, bin, fin, fin);
      end
    end
    wait_idle("stream_idle");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_last;
    reset = 1'b1; start_operation = 1'b0; opcode = 2'd0; use_source1 = 1'b0;
    source0_valid = 1'b0; source0_coefficient = '0; source0_last = 1'b0;
    source1_valid = 1'b0; source1_coefficient = '0; source1_last = 1'b0;
    m_run = 0; m_bin = 0; m_err = 0; m_op = OP_ADD; m_cnt = 0;
    tick(); tick();
    chk("rst_dest_valid", 32'(destination_valid), 32'd0);
    chk("rst_dest_coeff", 32'(destination_coefficient), 32'd0);
    chk("rst_dest_last", 32'(destination_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    tick();

    // ADD ramp: exactly one last beat expected.
    base_last = n_last;
    stream(OP_ADD, 1'b1, 0);
    chk("add_one_last", 32'(n_last - base_last), 32'd1);

    stream(OP_ADD, 1'b1, 1);
    stream(OP_SUB, 1'b1, 2);
    stream(OP_NEG, 1'b0, 3);
    stream(OP_ADD, 1'b1, 4);
    stream(OP_SUB, 1'b1, 4);
    stream(OP_NEG, 1'b0, 4);

    // Latency and busy fall on a single-element window (early last).
    chk("idle_busy", 32'(busy), 32'd0);
    start_op(OP_PASS, 1'b0);
    send(7, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lat_n_valid", 32'(destination_valid), 32'd0);
    chk("lat_n_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_n1_valid", 32'(destination_valid), 32'd1);
    chk("lat_n1_last", 32'(destination_last), 32'd1);
    chk("lat_n1_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_n2_valid", 32'(destination_valid), 32'd0);
    chk("lat_n2_busy", 32'(busy), 32'd0);
    chk("lat_err", 32'(error), 32'(m_err));

    // Unpaired source0 on a binary op is dropped and flags error.
    start_op(OP_ADD, 1'b1);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 2) send(11, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      send(i, 2 * i, 1'b1, 1'b1, i == TOTAL - 1, i == TOTAL - 1);
    end
    wait_idle("mismatch_idle");
    chk("mismatch_err", 32'(error), 32'd1);

    // Last at element 3 closes the window early with error.
    start_op(OP_SUB, 1'b1);
    for (int i = 0; i < 4; i++) send(i + 20, i, 1'b1, 1'b1, i == 3, i == 3);
    wait_idle("early_idle");
    chk("early_err", 32'(error), 32'd1);

    // Reset 10 elements in, with a start pulse coincident with reset.
    start_op(OP_ADD, 1'b1);
    for (int i = 0; i < 10; i++) send(i, i + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    start_operation = 1'b1;
    tick();
    start_operation = 1'b0;
    sb.delete();
    m_run = 0; m_err = 0;
    chk("mid_rst_valid", 32'(destination_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_start_ignored", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(destination_valid), 32'd0);
    stream(OP_PASS, 1'b0, 4);

    // Operand equal to its modulus.
    start_op(OP_PASS, 1'b0);
    for (int i = 0; i < TOTAL; i++)
      send((i == 0) ? int'(PRIMES[0]) : int'($urandom % 32'(PRIMES[i % NPRIMES])),
           0, 1'b1, 1'b0, i == TOTAL - 1, 1'b0);
    wait_idle("range_idle");
`ifdef RNS_ALU_RANGE_CHECK_EN
    chk("range_err", 32'(error), 32'd1);
`else
    chk("range_err", 32'(error), 32'd0);
`endif

    chk("total_lasts", 32'(n_last), 32'(m_lasts));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
